reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Register-write scoreboard on the writer side of the ID-stage RAW hazard check.
- Records every destination-register write as it issues and releases it when the write retires at writeback.
- Holds a per-register pending count and drives a busy vector and a read-ready verdict to decode/issue.
- Replaces per-stage exe/mem/wb destination compares with tracked state, so in-flight depth is not tied to pipeline stage count.

Parameters:
- NREG, 32, number of architectural GPRs; register 0 is hard-wired and never tracked.
- CNT_W, 2, pending-count width per register; MAX = 2^CNT_W - 1 = 3 writes in flight per register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction issuing this cycle.
- issue_write_type  in  3  write control {0:wb,1:mem,2:exe}; 3'b000 means no register write.
- issue_wnum  in  5  destination register of the issuing instruction.
- issue_ready  out  1  scoreboard can accept this issue (combinational).
- wb_valid  in  1  a register write retires this cycle.
- wb_write_type  in  3  write type of the retiring instruction; 3'b000 means no write.
- wb_wnum  in  5  retiring destination register.
- flush  in  1  squash all in-flight writes.
- read_type  in  2  operand use: bit0 = RR1 used, bit1 = RR2 used.
- RR1  in  5  source register 1.
- RR2  in  5  source register 2.
- rd_ready  out  1  no pending write to any used source (combinational from state).
- busy  out  NREG  bit i set while cnt[i] != 0; bit 0 always 0.
- err_underflow  out  1  sticky flag: retire arrived for a register with cnt == 0.

Behaviour:
- Reset (async, resetn=0): all cnt[i]=0, busy=0, err_underflow=0. issue_ready=1 and rd_ready=1 once inputs are quiet. Reset mid-operation discards all pending state immediately.
- Write qualifiers:
  - Issue is a write ("issue_w") when issue_valid, |issue_write_type, and issue_wnum != 0.
  - Retire is a write ("wb_w") when wb_valid, |wb_write_type, and wb_wnum != 0.
- Issue handshake: issue_ready = !(issue_w && cnt[issue_wnum]==MAX && !(wb_w && wb_wnum==issue_wnum)).
  - Issue is accepted when issue_valid && issue_ready.
  - Non-writing issues are always accepted and change no state.
- Counter update per register i (t -> t+1):
  - +1 if issue_w is accepted to i.
  - -1 if wb_w targets i and cnt[i] != 0.
  - Issue and retire to the same register in the same cycle net to 0.
  - The counter never wraps. Saturation is prevented by issue_ready; underflow is blocked and sets err_underflow, which stays set until reset.
- flush: next cycle all cnt = 0.
  - flush overrides any same-cycle issue or retire.
  - err_underflow is not cleared by flush.
- Latency:
  - An issue accepted in cycle t sets busy and affects rd_ready from cycle t+1.
  - A retire in cycle t clears the register from cycle t+1.
  - No same-cycle bypass from the issue or wb ports into rd_ready.
- rd_ready = !((read_type[0] && RR1!=0 && cnt[RR1]!=0) || (read_type[1] && RR2!=0 && cnt[RR2]!=0)).
  - read_type=2'b00 gives rd_ready=1.
  - RR1==RR2 is legal.
- Register 0: never counted. Issue or retire to register 0 is ignored with no error, and busy[0] is tied to 0.

Decomposition:
- Shared package holds:
  - WT_NONE=3'b000, WT_WB=3'b001, WT_MEM=3'b010, WT_EXE=3'b100
  - RT_RS=2'b01, RT_RT=2'b10, RT_RTRS=2'b11
  - NREG and CNT_W defaults.
- One sub-module, sb_cnt_cell: one register's up/down saturating counter.
  - Inputs: inc, dec, flush.
  - Outputs: count, nonzero, at_max, underflow_pulse.
  - Instantiated NREG-1 times by generate.

Test Plan:
- Reset, then issue_w to r5 at t0 -> busy[5]=1 at t1. Query read_type=01, RR1=5 -> rd_ready=0. wb r5 at t2 -> busy[5]=0 and rd_ready=1 at t3.
- Three issues to r7 in t0..t2, fourth held at t3 -> issue_ready=0. At t4 issue plus retire r7 in the same cycle -> issue_ready=1, cnt[7] stays 3. Then three retires -> busy[7]=0.
- Issues to r0 and issue_write_type=000 to r9 -> busy stays 0, issue_ready=1, no error.
- Issue r3 and r4, then assert flush together with an issue to r6 -> next cycle busy=0 and r6 not recorded.
- wb r12 with cnt[12]=0 -> err_underflow=1 next cycle, cnt[12] stays 0. Flag survives flush and clears only on resetn=0.
- Pending r8, query read_type=10, RR1=8, RR2=2 -> rd_ready=1. Switch read_type=11 -> rd_ready=0. Assert resetn=0 mid-test -> busy=0 immediately (asynchronous).

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared write/read type encodings and scoreboard sizing defaults
package reg_scoreboard_pkg;

    localparam int NREG_DEF  = 32;
    localparam int CNT_W_DEF = 2;

    typedef enum logic [2:0] {
        WT_NONE = 3'b000,
        WT_WB   = 3'b001,
        WT_MEM  = 3'b010,
        WT_EXE  = 3'b100
    } wt_e;

    typedef enum logic [1:0] {
        RT_RS   = 2'b01,
        RT_RT   = 2'b10,
        RT_RTRS = 2'b11
    } rt_e;

endpackage

// File: rtl/reg_scoreboard_cnt_cell.sv
// sb_cnt_cell: per-register pending-write counter that never wraps and flags illegal retires
module sb_cnt_cell #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             dec,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             at_max,
    output logic             underflow_pulse
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_dec_ok;

    assign count           = r_cnt;
    assign nonzero         = |r_cnt;
    assign at_max          = &r_cnt;
    assign w_dec_ok        = dec && nonzero;
    assign underflow_pulse = dec && !nonzero;

    // flush wins; a simultaneous legal inc and dec cancel; saturation is prevented upstream by issue_ready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                  r_cnt <= '0;
        else if (flush)               r_cnt <= '0;
        else if (inc && !w_dec_ok)    r_cnt <= r_cnt + 1'b1;
        else if (!inc && w_dec_ok)    r_cnt <= r_cnt - 1'b1;
    end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight register writes and reports busy registers and operand readiness
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    issue_valid,
    input  logic [2:0]              issue_write_type,
    input  logic [$clog2(NREG)-1:0] issue_wnum,
    output logic                    issue_ready,
    input  logic                    wb_valid,
    input  logic [2:0]              wb_write_type,
    input  logic [$clog2(NREG)-1:0] wb_wnum,
    input  logic                    flush,
    input  logic [1:0]              read_type,
    input  logic [$clog2(NREG)-1:0] RR1,
    input  logic [$clog2(NREG)-1:0] RR2,
    output logic                    rd_ready,
    output logic [NREG-1:0]         busy,
    output logic                    err_underflow
);

    localparam int AW = $clog2(NREG);

    logic [CNT_W-1:0] w_cnt [NREG];
    logic [NREG-1:0]  w_busy;
    logic [NREG-1:0]  w_at_max;
    logic [NREG-1:0]  w_uf;
    logic             w_issue_w;
    logic             w_wb_w;
    logic             w_issue_acc;
    logic             r_err;

    assign w_issue_w   = issue_valid && (issue_write_type != WT_NONE) && (issue_wnum != '0);
    assign w_wb_w      = wb_valid && (wb_write_type != WT_NONE) && (wb_wnum != '0);
    assign issue_ready = !(w_issue_w && w_at_max[issue_wnum] && !(w_wb_w && wb_wnum == issue_wnum));
    assign w_issue_acc = w_issue_w && issue_ready;

    assign w_cnt[0]    = '0;
    assign w_busy[0]   = 1'b0;
    assign w_at_max[0] = 1'b0;
    assign w_uf[0]     = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_cell
        sb_cnt_cell #(.CNT_W(CNT_W)) u_cell (
            .clk             (clk),
            .resetn          (resetn),
            .inc             (w_issue_acc && issue_wnum == AW'(g)),
            .dec             (w_wb_w && wb_wnum == AW'(g)),
            .flush           (flush),
            .count           (w_cnt[g]),
            .nonzero         (w_busy[g]),
            .at_max          (w_at_max[g]),
            .underflow_pulse (w_uf[g])
        );
    end

    assign busy          = w_busy;
    assign err_underflow = r_err;
    assign rd_ready      = !((read_type[0] && RR1 != '0 && w_cnt[RR1] != '0) ||
                             (read_type[1] && RR2 != '0 && w_cnt[RR2] != '0));

    // sticky underflow flag; only reset clears it, flush deliberately does not
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_err <= 1'b0;
        else         r_err <= r_err || (|w_uf);
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vector table plus randomized run against a counting reference model
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_write_type = '0;
    logic [4:0]  issue_wnum = '0;
    logic        issue_ready;
    logic        wb_valid = 1'b0;
    logic [2:0]  wb_write_type = '0;
    logic [4:0]  wb_wnum = '0;
    logic        flush = 1'b0;
    logic [1:0]  read_type = '0;
    logic [4:0]  RR1 = '0;
    logic [4:0]  RR2 = '0;
    logic        rd_ready;
    logic [31:0] busy;
    logic        err_underflow;

    reg_scoreboard dut (
        .clk              (clk),
        .resetn           (resetn),
        .issue_valid      (issue_valid),
        .issue_write_type (issue_write_type),
        .issue_wnum       (issue_wnum),
        .issue_ready      (issue_ready),
        .wb_valid         (wb_valid),
        .wb_write_type    (wb_write_type),
        .wb_wnum          (wb_wnum),
        .flush            (flush),
        .read_type        (read_type),
        .RR1              (RR1),
        .RR2              (RR2),
        .rd_ready         (rd_ready),
        .busy             (busy),
        .err_underflow    (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        iv;
        logic [2:0]  iwt;
        logic [4:0]  iwn;
        logic        wv;
        logic [2:0]  wwt;
        logic [4:0]  wwn;
        logic        fl;
        logic [1:0]  rt;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_ir;
        logic        e_rr;
        logic [31:0] e_busy;
        logic        e_err;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int m_cnt [32];
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int iv, iwt, iwn, wv, wwt, wwn, fl, rt, r1, r2,
                                input int e_ir, e_rr, input logic [31:0] e_busy, input int e_err);
        vec_t v;
        v.iv = iv[0]; v.iwt = iwt[2:0]; v.iwn = iwn[4:0];
        v.wv = wv[0]; v.wwt = wwt[2:0]; v.wwn = wwn[4:0];
        v.fl = fl[0]; v.rt = rt[1:0]; v.r1 = r1[4:0]; v.r2 = r2[4:0];
        v.e_ir = e_ir[0]; v.e_rr = e_rr[0]; v.e_busy = e_busy; v.e_err = e_err[0];
        return v;
    endfunction

    function automatic bit m_issue_w();
        return issue_valid && issue_write_type != 3'b000 && issue_wnum != 0;
    endfunction

    function automatic bit m_wb_w();
        return wb_valid && wb_write_type != 3'b000 && wb_wnum != 0;
    endfunction

    function automatic bit m_ir();
        return !(m_issue_w() && m_cnt[issue_wnum] == 3 && !(m_wb_w() && wb_wnum == issue_wnum));
    endfunction

    function automatic bit m_rr();
        bit p1, p2;
        p1 = read_type[0] && RR1 != 0 && m_cnt[RR1] != 0;
        p2 = read_type[1] && RR2 != 0 && m_cnt[RR2] != 0;
        return !(p1 || p2);
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] v = '0;
        for (int i = 1; i < 32; i++) v[i] = (m_cnt[i] != 0);
        return v;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    endfunction

    task automatic cycle(input string tag);
        bit acc, wbw;
        int iw, bw, pre;
        #1;
        chk({tag, " issue_ready"}, 32'(issue_ready), 32'(m_ir()));
        chk({tag, " rd_ready"}, 32'(rd_ready), 32'(m_rr()));
        acc = m_issue_w() && m_ir();
        wbw = m_wb_w();
        iw = int'(issue_wnum);
        bw = int'(wb_wnum);
        pre = m_cnt[bw];
        @(posedge clk);
        if (wbw && pre == 0) m_err = 1;
        if (flush) m_clear();
        else begin
            if (acc) m_cnt[iw] = m_cnt[iw] + 1;
            if (wbw && pre != 0) m_cnt[bw] = m_cnt[bw] - 1;
        end
        @(negedge clk);
        chk({tag, " busy"}, busy, m_busy());
        chk({tag, " err_underflow"}, 32'(err_underflow), 32'(m_err));
    endtask

    task automatic apply(input vec_t v);
        issue_valid = v.iv; issue_write_type = v.iwt; issue_wnum = v.iwn;
        wb_valid = v.wv; wb_write_type = v.wwt; wb_wnum = v.wwn;
        flush = v.fl; read_type = v.rt; RR1 = v.r1; RR2 = v.r2;
    endtask

    task automatic idle();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    endtask

    initial begin
        vec_t tbl[$];
        m_clear();
        m_err = 0;

        tbl.push_back(mk(1, WT_WB, 5,  0, 0, 0,      0, 1, 5, 0,  1, 1, 32'h1 << 5, 0));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,      0, 1, 5, 0,  1, 0, 32'h1 << 5, 0));
        tbl.push_back(mk(0, 0, 0,      1, WT_WB, 5,  0, 1, 5, 0,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,      0, 1, 5, 0,  1, 1, 0, 0));
        tbl.push_back(mk(1, WT_EXE, 7, 0, 0, 0,      0, 0, 0, 0,  1, 1, 32'h1 << 7, 0));
        tbl.push_back(mk(1, WT_EXE, 7, 0, 0, 0,      0, 0, 0, 0,  1, 1, 32'h1 << 7, 0));
        tbl.push_back(mk(1, WT_EXE, 7, 0, 0, 0,      0, 0, 0, 0,  1, 1, 32'h1 << 7, 0));
        tbl.push_back(mk(1, WT_EXE, 7, 0, 0, 0,      0, 0, 0, 0,  0, 1, 32'h1 << 7, 0));
        tbl.push_back(mk(1, WT_EXE, 7, 1, WT_EXE, 7, 0, 0, 0, 0,  1, 1, 32'h1 << 7, 0));
        tbl.push_back(mk(0, 0, 0,      1, WT_WB, 7,  0, 0, 0, 0,  1, 1, 32'h1 << 7, 0));
        tbl.push_back(mk(0, 0, 0,      1, WT_WB, 7,  0, 0, 0, 0,  1, 1, 32'h1 << 7, 0));
        tbl.push_back(mk(0, 0, 0,      1, WT_WB, 7,  0, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(1, WT_WB, 0,  0, 0, 0,      0, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(1, WT_NONE, 9, 0, 0, 0,     0, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,      1, WT_WB, 0,  0, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(1, WT_MEM, 3, 0, 0, 0,      0, 0, 0, 0,  1, 1, 32'h1 << 3, 0));
        tbl.push_back(mk(1, WT_MEM, 4, 0, 0, 0,      0, 0, 0, 0,  1, 1, 32'h18, 0));
        tbl.push_back(mk(1, WT_MEM, 6, 0, 0, 0,      1, 0, 0, 0,  1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,      0, 3, 6, 6,  1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,      1, WT_WB, 12, 0, 0, 0, 0,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,      1, 0, 0, 0,  1, 1, 0, 1));
        tbl.push_back(mk(1, WT_WB, 8,  0, 0, 0,      0, 0, 0, 0,  1, 1, 32'h1 << 8, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,      0, 2, 8, 2,  1, 1, 32'h1 << 8, 1));
        tbl.push_back(mk(0, 0, 0,      0, 0, 0,      0, 3, 8, 2,  1, 0, 32'h1 << 8, 1));

        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset err_underflow", 32'(err_underflow), 0);
        chk("reset issue_ready", 32'(issue_ready), 1);
        chk("reset rd_ready", 32'(rd_ready), 1);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            #1;
            chk($sformatf("vec%0d issue_ready", i), 32'(issue_ready), 32'(tbl[i].e_ir));
            chk($sformatf("vec%0d rd_ready", i), 32'(rd_ready), 32'(tbl[i].e_rr));
            cycle($sformatf("vec%0d model", i));
            chk($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d err_underflow", i), 32'(err_underflow), 32'(tbl[i].e_err));
        end

        idle();
        read_type = RT_RTRS; RR1 = 5'd8; RR2 = 5'd2;
        #2;
        resetn = 1'b0;
        #1;
        chk("async reset busy", busy, 0);
        chk("async reset err_underflow", 32'(err_underflow), 0);
        chk("async reset rd_ready", 32'(rd_ready), 1);
        m_clear();
        m_err = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                idle();
                resetn = 1'b0;
                #1;
                chk("mid reset busy", busy, 0);
                m_clear();
                m_err = 0;
                @(negedge clk);
                resetn = 1'b1;
                @(negedge clk);
            end
            issue_valid      = ($urandom_range(0, 9) < 7);
            issue_write_type = 3'($urandom_range(0, 7));
            issue_wnum       = 5'($urandom_range(0, 7));
            wb_valid         = ($urandom_range(0, 1) == 1);
            wb_write_type    = 3'($urandom_range(0, 7));
            wb_wnum          = 5'($urandom_range(0, 7));
            flush            = !wb_valid && ($urandom_range(0, 29) == 0);
            read_type        = 2'($urandom_range(0, 3));
            RR1              = 5'($urandom_range(0, 7));
            RR2              = 5'($urandom_range(0, 7));
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
